// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width, line idle level.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line. Both flops reset to the idle
// level so a reset never produces a spurious start detect.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_CLK,
    input  logic i_RESET_N,
    input  logic i_D,
    output logic o_Q
);

    logic meta;

    // Shift the raw line through two flops.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            meta <= IDLE_LEVEL;
            o_Q  <= IDLE_LEVEL;
        end else begin
            meta <= i_D;
            o_Q  <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with valid/ready byte output, framing-error and overrun
// pulses. Define UART_RX_SYNC_EN to put a two-flop synchroniser on i_RX;
// without it i_RX must come from the i_CLK domain.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       i_CLK,
    input  logic       i_RESET_N,
    input  logic       i_RX,
    input  logic       i_DATA_READY,
    output logic [7:0] o_DATA,
    output logic       o_DATA_VALID,
    output logic       o_RX_BUSY,
    output logic       o_FRAME_ERR,
    output logic       o_OVERRUN
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .i_CLK     (i_CLK),
        .i_RESET_N (i_RESET_N),
        .i_D       (i_RX),
        .o_Q       (rx_s)
    );
`else
    assign rx_s = i_RX;
`endif

    rx_state_t              state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [2:0]             bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic                   stop_smp;
    logic                   stop_ok;
    logic                   load;

    // FSM and datapath registers.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Next-state: start confirm at mid-bit, then one sample per bit period.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_s != IDLE_LEVEL) begin
                    cnt_nxt   = '0;
                    state_nxt = (HALF == 0) ? DATA : START;
                end
            end
            START: begin
                if (cnt == HALF_C) begin
                    cnt_nxt   = '0;
                    state_nxt = (rx_s != IDLE_LEVEL) ? DATA : IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST_C) begin
                    cnt_nxt            = '0;
                    shreg_nxt[bit_cnt] = rx_s;
                    bit_nxt            = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1))
                        state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST_C) begin
                    cnt_nxt   = '0;
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A good stop bit loads only if the output slot is free or being drained.
    assign stop_ok = stop_smp && (rx_s == IDLE_LEVEL);
    assign load    = stop_ok && (!o_DATA_VALID || i_DATA_READY);

    // Registered outputs: byte slot, handshake and one-cycle status pulses.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            o_DATA       <= 8'h00;
            o_DATA_VALID <= 1'b0;
            o_RX_BUSY    <= 1'b0;
            o_FRAME_ERR  <= 1'b0;
            o_OVERRUN    <= 1'b0;
        end else begin
            if (load)
                o_DATA <= shreg;
            if (load)
                o_DATA_VALID <= 1'b1;
            else if (o_DATA_VALID && i_DATA_READY)
                o_DATA_VALID <= 1'b0;
            o_RX_BUSY   <= (state_nxt != IDLE);
            o_FRAME_ERR <= stop_smp && !stop_ok;
            o_OVERRUN   <= stop_ok && !load;
        end
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive-side counterpart to the team's UART transmitter. It deserialises an 8N1 frame from a single serial line: one start bit, eight data bits sent LSB first, and one stop bit. The byte is presented on a valid/ready output port, with framing-error and overrun reporting. It sits between the pad or loopback line and the byte-consuming logic, in the same clock domain as the transmitter.

## Interface
Parameters:
- CLKS_PER_BIT, default 1: clock cycles per serial bit, legal range ≥1. The value 1 matches the transmitter's one-bit-per-clock rate.

Ports:
- i_CLK  input  1  system clock; all logic is rising-edge.
- i_RESET_N  input  1  asynchronous, active-low reset.
- i_RX  input  1  serial line; idles high.
- i_DATA_READY  input  1  consumer accepts o_DATA while o_DATA_VALID=1.
- o_DATA  output  8  received byte.
- o_DATA_VALID  output  1  o_DATA holds an unconsumed byte.
- o_RX_BUSY  output  1  high whenever the FSM is not in IDLE.
- o_FRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low.
- o_OVERRUN  output  1  one-cycle pulse when a good frame is dropped because the previous byte was not consumed.

## Operation
- **Constants.**
  - HALF = (CLKS_PER_BIT-1)/2, using integer division.
  - The bit counter is 3 bits; the cycle counter is max(1, $clog2(CLKS_PER_BIT)) bits.
- **Sampled line.** rx_s is i_RX after the optional synchroniser (see Configuration).
- **IDLE.**
  - rx_s=0 is a start detect, and the cycle counter is cleared.
  - If HALF=0, the start is confirmed in the detect cycle and the FSM goes directly to DATA.
  - Otherwise the FSM goes to START.
- **START.**
  - The cycle counter increments each cycle.
  - When the counter equals HALF, rx_s is re-checked:
    - rx_s=0 confirms the start: go to DATA and clear the counter.
    - rx_s=1 is a false start: return to IDLE with no flags raised.
- **DATA.**
  - Once the counter reaches CLKS_PER_BIT-1, rx_s is shifted into bit position bit_count (LSB first), the counter clears, and bit_count increments.
  - After bit 7 the FSM goes to STOP. bit_count wraps to 0.
- **STOP.** One CLKS_PER_BIT interval later, rx_s is sampled and the FSM returns to IDLE in the same cycle.
  - **Stop bit = 1, o_DATA_VALID=0 or i_DATA_READY=1:** load o_DATA and set o_DATA_VALID.
  - **Stop bit = 1, o_DATA_VALID=1 and i_DATA_READY=0:** drop the new byte, keep the old one, and pulse o_OVERRUN.
  - **Stop bit = 0:** discard the byte and pulse o_FRAME_ERR. o_DATA and o_DATA_VALID are unchanged.
- **Handshake.**
  - o_DATA_VALID clears on any cycle where o_DATA_VALID=1, i_DATA_READY=1 and no new load occurs.
  - o_DATA is stable while o_DATA_VALID=1.
- **Reset.**
  - Reset is asynchronous, and the FSM may be mid-frame when it arrives.
  - Reset forces: FSM=IDLE, counters=0, shift register=0, o_DATA=8'h00, o_DATA_VALID=0, o_RX_BUSY=0, o_FRAME_ERR=0, o_OVERRUN=0, synchroniser flops=1.
  - The frame in progress is lost.
  - The first start detect can occur on the first edge after deassertion.

## Timing
- All outputs are registered.
- **Bit sampling.** Measured from the cycle in which the start is confirmed, data bit k is sampled CLKS_PER_BIT·(k+1) cycles later (k=0..7), and the stop bit CLKS_PER_BIT·9 cycles later.
- **Output timing.** o_DATA_VALID, o_FRAME_ERR and o_OVERRUN update on the edge that samples the stop bit, so they are visible the following cycle.
- **CLKS_PER_BIT=1 latency.** With the synchroniser disabled, o_DATA_VALID rises 10 cycles after i_RX falls for the start bit. The synchroniser adds 2 cycles.
- **Back-to-back frames.** The FSM is in IDLE on the cycle after the stop sample. A start bit immediately following the stop bit is detected with no gap.

## Configuration
- **UART_RX_SYNC_EN defined:**
  - i_RX passes through a two-flop synchroniser with reset value 1 before reaching rx_s.
  - All latencies grow by 2 cycles.
- **UART_RX_SYNC_EN undefined:**
  - rx_s = i_RX directly.
  - Legal only when i_RX is driven from the i_CLK domain, for example by the transmitter in loopback.

## Structure
- **Shared package uart_pkg:**
  - state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - DATA_BITS=8;
  - line idle level IDLE_LEVEL=1'b1.
- **Sub-module uart_rx_sync:**
  - two-flop synchroniser, ports i_CLK, i_RESET_N, i_D, o_Q;
  - instantiated only under UART_RX_SYNC_EN.

## Test plan
- **Nominal frame.** CLKS_PER_BIT=1, no sync. Drive i_RX = 0, then 0,1,0,1,0,0,0,1, then 1. Expected: o_DATA=8'h8A, o_DATA_VALID high 10 cycles after the start falls, no flags.
- **Backpressure and overrun.** Hold i_DATA_READY=0 and send 8'h8A, then 8'h55 back-to-back. Expected: o_DATA stays 8'h8A, one-cycle o_OVERRUN at the second stop sample. Raising i_DATA_READY for one cycle clears o_DATA_VALID.
- **Simultaneous ready and new byte.** Send 8'h55 with i_DATA_READY=1 in the cycle its stop bit is sampled while 8'h8A is pending. Expected: o_DATA=8'h55, o_DATA_VALID stays 1, no o_OVERRUN.
- **Framing error.** Send 8'hFF with the stop bit driven 0. Expected: one-cycle o_FRAME_ERR, o_DATA_VALID stays 0, FSM back in IDLE.
- **False start.** CLKS_PER_BIT=16. Pulse i_RX low for 3 cycles. Expected: return to IDLE at counter=7, o_RX_BUSY low again, no flags. A following valid 8'hA5 frame is received correctly.
- **Reset mid-frame.** Assert i_RESET_N=0 after data bit 3. Expected: all outputs 0 immediately (asynchronous). A subsequent 8'h3C frame is received correctly.
